// File: rtl/tt_sweep_pkg.sv
// Shared types and constants for the truth-table sweep controller.
package tt_sweep_pkg;

  localparam int TT_W       = 16;
  localparam int IDX_W      = 4;
  localparam int SETTLE_MIN = 2;
  localparam int TMR_W      = 8;

  typedef enum logic [2:0] {
    IDLE,
    APPLY,
    SETTLE,
    SAMPLE,
    DONE
  } state_e;

  // Timer reload value: the timer expires when it reaches zero, so a window of
  // N cycles needs a load of N-1. Short windows are stretched to SETTLE_MIN so
  // the two synchronizer flops always fit inside the settle window.
  function automatic logic [TMR_W-1:0] settle_load(input int cycles);
    int c;
    c = cycles;
    if (c < SETTLE_MIN) c = SETTLE_MIN;
    if (c > 255) c = 255;
    return TMR_W'(c - 1);
  endfunction

endpackage

// File: rtl/tt_settle_timer.sv
// Loadable 8-bit down-counter; expired is the terminal-count compare.
module tt_settle_timer
  import tt_sweep_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [TMR_W-1:0] load_val,
  output logic             expired
);

  logic [TMR_W-1:0] cnt_q;

  // Count down to zero and hold there until reloaded.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign expired = (cnt_q == '0);

endmodule

// File: rtl/tt_sweep_ctrl.sv
// Self-test sequencer: steps a 4-input logic netlist through all 16 vectors,
// samples its output through a 2-flop synchronizer and compares against
// EXPECTED_TT (MSB-first: vector i maps to bit 15-i).
// Optional first-failure log enabled by defining TT_SWEEP_FAIL_LOG_EN.
//
// state  | meaning
// IDLE   | netlist inputs held at 0, waiting for start
// APPLY  | register vector idx onto in1..in4, load settle timer
// SETTLE | wait for netlist output and synchronizer to settle
// SAMPLE | record synchronized output, compare, advance or finish
// DONE   | one-cycle done pulse, inputs already back at 0
module tt_sweep_ctrl
  import tt_sweep_pkg::*;
#(
  parameter logic [TT_W-1:0] EXPECTED_TT   = 16'h2D30,
  parameter int              SETTLE_CYCLES = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  output logic            in1,
  output logic            in2,
  output logic            in3,
  output logic            in4,
  input  logic            out_i,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [TT_W-1:0] obs_tt
`ifdef TT_SWEEP_FAIL_LOG_EN
  ,
  output logic            fail_valid,
  output logic [IDX_W-1:0] fail_idx
`endif
);

  localparam logic [TMR_W-1:0] SETTLE_LOAD = settle_load(SETTLE_CYCLES);
  localparam logic [IDX_W-1:0] IDX_LAST    = IDX_W'(TT_W - 1);

  state_e           state_q;
  logic [IDX_W-1:0] idx_q;
  logic [IDX_W-1:0] vec_q;
  logic             busy_q;
  logic             done_q;
  logic             pass_q;
  logic [TT_W-1:0]  obs_q;
  logic             sync1_q;
  logic             sync2_q;
  logic             tmr_load;
  logic             tmr_expired;
`ifdef TT_SWEEP_FAIL_LOG_EN
  logic             fail_valid_q;
  logic [IDX_W-1:0] fail_idx_q;
`endif

  assign tmr_load = (state_q == APPLY);

  tt_settle_timer u_settle_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (SETTLE_LOAD),
    .expired  (tmr_expired)
  );

  // Two-flop synchronizer for the asynchronous netlist output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= out_i;
      sync2_q <= sync1_q;
    end
  end

  // Sweep sequencer with registered stimulus and result outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      vec_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      obs_q   <= '0;
`ifdef TT_SWEEP_FAIL_LOG_EN
      fail_valid_q <= 1'b0;
      fail_idx_q   <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          vec_q <= '0;
          if (start) begin
            state_q <= APPLY;
            idx_q   <= '0;
            obs_q   <= '0;
            pass_q  <= 1'b1;
            busy_q  <= 1'b1;
`ifdef TT_SWEEP_FAIL_LOG_EN
            fail_valid_q <= 1'b0;
            fail_idx_q   <= '0;
`endif
          end
        end
        APPLY: begin
          vec_q   <= idx_q;
          state_q <= SETTLE;
        end
        SETTLE: begin
          if (tmr_expired) state_q <= SAMPLE;
        end
        SAMPLE: begin
          obs_q[IDX_LAST - idx_q] <= sync2_q;
          if (sync2_q != EXPECTED_TT[IDX_LAST - idx_q]) begin
            pass_q <= 1'b0;
`ifdef TT_SWEEP_FAIL_LOG_EN
            if (!fail_valid_q) begin
              fail_valid_q <= 1'b1;
              fail_idx_q   <= idx_q;
            end
`endif
          end
          // Exit on the last vector instead of letting idx wrap to 0.
          if (idx_q == IDX_LAST) begin
            state_q <= DONE;
            done_q  <= 1'b1;
            vec_q   <= '0;
          end else begin
            idx_q   <= idx_q + 1'b1;
            state_q <= APPLY;
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign {in1, in2, in3, in4} = vec_q;
  assign busy   = busy_q;
  assign done   = done_q;
  assign pass   = pass_q;
  assign obs_tt = obs_q;
`ifdef TT_SWEEP_FAIL_LOG_EN
  assign fail_valid = fail_valid_q;
  assign fail_idx   = fail_idx_q;
`endif

endmodule

// File: tb/tb_tt_sweep_ctrl.sv
// Scoreboard bench for tt_sweep_ctrl. Two instances: default settle (8) with a
// combinational netlist model, and SETTLE_CYCLES=0 (stretched to 2) with a
// netlist model whose output lags its inputs by almost a full clock period.
module tb_tt_sweep_ctrl;

  localparam logic [15:0] EXP_TT = 16'h2D30;

  typedef struct {
    int          acc;
    int          dlen;
    logic [15:0] obs;
    logic        pss;
    logic [3:0]  fidx;
    logic        fval;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic        rst    [2];
  logic        start  [2];
  logic [15:0] ckt_tt [2];
  logic        in1_w  [2];
  logic        in2_w  [2];
  logic        in3_w  [2];
  logic        in4_w  [2];
  logic        busy_w [2];
  logic        done_w [2];
  logic        pass_w [2];
  logic [15:0] obs_w  [2];
  logic        last_pass [2];
  logic [15:0] last_obs  [2];
`ifdef TT_SWEEP_FAIL_LOG_EN
  logic        fval_w [2];
  logic [3:0]  fidx_w [2];
`endif
  logic out0;
  logic out1;

  exp_t q0[$];
  exp_t q1[$];

  always @(posedge clk) cyc <= cyc + 1;

  assign out0 = ckt_tt[0][~{in1_w[0], in2_w[0], in3_w[0], in4_w[0]}];

  initial begin
    out1 = 1'b0;
    forever begin
      @(posedge clk);
      #9;
      out1 = ckt_tt[1][~{in1_w[1], in2_w[1], in3_w[1], in4_w[1]}];
    end
  end

  tt_sweep_ctrl #(.EXPECTED_TT(EXP_TT), .SETTLE_CYCLES(8)) dut0 (
    .clk(clk), .rst(rst[0]), .start(start[0]),
    .in1(in1_w[0]), .in2(in2_w[0]), .in3(in3_w[0]), .in4(in4_w[0]),
    .out_i(out0), .busy(busy_w[0]), .done(done_w[0]), .pass(pass_w[0]),
    .obs_tt(obs_w[0])
`ifdef TT_SWEEP_FAIL_LOG_EN
    , .fail_valid(fval_w[0]), .fail_idx(fidx_w[0])
`endif
  );

  tt_sweep_ctrl #(.EXPECTED_TT(EXP_TT), .SETTLE_CYCLES(0)) dut1 (
    .clk(clk), .rst(rst[1]), .start(start[1]),
    .in1(in1_w[1]), .in2(in2_w[1]), .in3(in3_w[1]), .in4(in4_w[1]),
    .out_i(out1), .busy(busy_w[1]), .done(done_w[1]), .pass(pass_w[1]),
    .obs_tt(obs_w[1])
`ifdef TT_SWEEP_FAIL_LOG_EN
    , .fail_valid(fval_w[1]), .fail_idx(fidx_w[1])
`endif
  );

  task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s[%0d] actual=%0h required=%0h t=%0t", name, k, act, req, $time);
    end
  endtask

  // Cycles per vector: APPLY + effective settle window + SAMPLE.
  function automatic int s2(input int k);
    return (k == 0) ? (8 + 2) : (2 + 2);
  endfunction

  function automatic int qsize(input int k);
    return (k == 0) ? q0.size() : q1.size();
  endfunction

  // Reference: the observed table is whatever the netlist implements; the
  // verdict and first-failure index follow from comparing it with EXP_TT.
  function automatic exp_t make_exp(input int k, input int acc, input logic [15:0] ckt);
    exp_t e;
    bit found;
    e.acc  = acc;
    e.dlen = 16 * s2(k) + 1;
    e.obs  = ckt;
    e.pss  = (ckt == EXP_TT);
    e.fval = (ckt != EXP_TT);
    e.fidx = 4'd0;
    found  = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (!found && ckt[15-i] != EXP_TT[15-i]) begin
        e.fidx = 4'(i);
        found  = 1'b1;
      end
    end
    return e;
  endfunction

  task automatic push_exp(input int k, input exp_t e);
    if (k == 0) q0.push_back(e);
    else q1.push_back(e);
  endtask

  task automatic check_reset(input int k);
    chk("rst_busy", k, busy_w[k], 0);
    chk("rst_done", k, done_w[k], 0);
    chk("rst_pass", k, pass_w[k], 0);
    chk("rst_obs", k, obs_w[k], 0);
    chk("rst_in", k, {in1_w[k], in2_w[k], in3_w[k], in4_w[k]}, 0);
`ifdef TT_SWEEP_FAIL_LOG_EN
    chk("rst_fval", k, fval_w[k], 0);
    chk("rst_fidx", k, fidx_w[k], 0);
`endif
  endtask

  // Monitor: per-cycle busy / stimulus checks, result checks when done shows.
  task automatic monitor_one(input int k);
    exp_t e;
    bit   have;
    int   n;
    int   evec;
    have = (qsize(k) != 0);
    if (have) e = (k == 0) ? q0[0] : q1[0];
    n = have ? (cyc - e.acc) : 0;
    evec = (have && n >= 2 && n <= e.dlen - 1) ? ((n - 2) / s2(k)) : 0;
    chk("busy", k, busy_w[k], (have && n >= 1) ? 1 : 0);
    chk("in_vec", k, {in1_w[k], in2_w[k], in3_w[k], in4_w[k]}, evec);
    if (done_w[k]) begin
      if (!have) begin
        chk("done_unexpected", k, done_w[k], 0);
      end else begin
        chk("done_cycle", k, n, e.dlen);
        chk("obs_tt", k, obs_w[k], e.obs);
        chk("pass", k, pass_w[k], e.pss);
`ifdef TT_SWEEP_FAIL_LOG_EN
        chk("fail_valid", k, fval_w[k], e.fval);
        chk("fail_idx", k, fidx_w[k], e.fidx);
`endif
        last_pass[k] = e.pss;
        last_obs[k]  = e.obs;
        if (k == 0) void'(q0.pop_front());
        else void'(q1.pop_front());
      end
    end else if (have && n >= e.dlen) begin
      chk("done_missing", k, done_w[k], 1);
      if (k == 0) void'(q0.pop_front());
      else void'(q1.pop_front());
    end
  endtask

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rst[k]) begin
        last_pass[k] = 1'b0;
        last_obs[k]  = '0;
        if (k == 0) q0.delete();
        else q1.delete();
      end else begin
        monitor_one(k);
      end
    end
  end

  task automatic start_sweep(input int k, input logic [15:0] ckt, output int acc);
    @(posedge clk); #2;
    chk("idle_pass", k, pass_w[k], last_pass[k]);
    chk("idle_obs", k, obs_w[k], last_obs[k]);
    ckt_tt[k] = ckt;
    start[k]  = 1'b1;
    acc = cyc;
    push_exp(k, make_exp(k, acc, ckt));
    @(posedge clk); #2;
    start[k] = 1'b0;
  endtask

  // Optionally pulses start at random points inside the sweep; all must be ignored.
  task automatic run_sweep(input int k, input logic [15:0] ckt, input bit pulses);
    int acc;
    int n;
    int dl;
    start_sweep(k, ckt, acc);
    dl = 16 * s2(k) + 1;
    for (int t = 0; t < 3000; t++) begin
      if (qsize(k) == 0) break;
      @(posedge clk); #2;
      n = cyc - acc;
      start[k] = pulses && n >= 2 && n <= dl - 3 && ($urandom_range(0, 7) == 0);
    end
    start[k] = 1'b0;
  endtask

  task automatic held_start(input int k, input logic [15:0] ckt);
    int acc;
    int dl;
    @(posedge clk); #2;
    chk("idle_pass", k, pass_w[k], last_pass[k]);
    ckt_tt[k] = ckt;
    start[k]  = 1'b1;
    acc = cyc;
    dl  = 16 * s2(k) + 1;
    for (int j = 0; j < 3; j++) push_exp(k, make_exp(k, acc + j * (dl + 1), ckt));
    while (cyc < acc + 2 * (dl + 1) + 1) begin
      @(posedge clk); #2;
    end
    start[k] = 1'b0;
    for (int t = 0; t < 3000; t++) begin
      if (qsize(k) == 0) break;
      @(posedge clk);
    end
  endtask

  task automatic reset_mid(input int k, input logic [15:0] ckt);
    int acc;
    start_sweep(k, ckt, acc);
    while (cyc < acc + 40) begin
      @(posedge clk); #2;
    end
    rst[k] = 1'b1;
    #1;
    check_reset(k);
    @(posedge clk); #2;
    check_reset(k);
    rst[k] = 1'b0;
    repeat (200) @(posedge clk);
  endtask

  function automatic logic [15:0] rand_tt();
    if ($urandom_range(0, 1) == 1) return EXP_TT ^ (16'h0001 << $urandom_range(0, 15));
    return 16'($urandom);
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1);
  end

  initial begin
    for (int k = 0; k < 2; k++) begin
      rst[k]    = 1'b1;
      start[k]  = 1'b0;
      ckt_tt[k] = EXP_TT;
    end
    repeat (3) @(posedge clk);
    #2;
    check_reset(0);
    check_reset(1);
    rst[0] = 1'b0;
    rst[1] = 1'b0;
    repeat (2) @(posedge clk);

    run_sweep(0, EXP_TT, 1'b0);
    run_sweep(0, 16'h0000, 1'b1);
    run_sweep(0, EXP_TT ^ 16'h0040, 1'b1);
    for (int r = 0; r < 4; r++) run_sweep(0, rand_tt(), 1'b1);
    held_start(0, rand_tt());
    reset_mid(0, rand_tt());
    run_sweep(0, EXP_TT, 1'b0);

    run_sweep(1, EXP_TT, 1'b0);
    run_sweep(1, 16'h0000, 1'b1);
    for (int r = 0; r < 3; r++) run_sweep(1, rand_tt(), 1'b1);
    held_start(1, EXP_TT);

    repeat (5) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
